// File: rtl/seq_det_arbiter_if.sv
// Bundle between the two requesters, the shared 1001 detector and seq_det_arbiter.
// The master side is the surrounding logic (requesters and detector); the slave side is the arbiter.
interface seq_det_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             ack0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             ack1;
  logic             det_clr;
  logic             det_w;
  logic             det_z;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output req0, data0, req1, data1, det_z,
    input  ack0, ack1, det_clr, det_w, busy, done, done_id, match_cnt
  );

  modport slave (
    input  req0, data0, req1, data1, det_z,
    output ack0, ack1, det_clr, det_w, busy, done, done_id, match_cnt
  );
endinterface

// File: rtl/seq_det_arbiter.sv
// Round-robin sharing of one serial 1001 detector between two byte requesters.
// Each granted word is shifted in MSB-first after a detector clear, and the z pulses are counted.
module seq_det_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic               clk,
  input logic               reset,
  seq_det_arbiter_if.slave  bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, TAIL, DONE} state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_gnt_q, last_gnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   acc_q, acc_d, acc_inc;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               det_clr_q, det_clr_d;
  logic               det_w_q, det_w_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               done_id_q, done_id_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic               win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_gnt_q  <= 1'b1;
      shreg_q     <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      det_clr_q   <= 1'b0;
      det_w_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_gnt_q  <= last_gnt_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      det_clr_q   <= det_clr_d;
      det_w_q     <= det_w_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  // Outputs are registered from the next state, so each output lines up with the state it belongs to.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_gnt_d  = last_gnt_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    det_clr_d   = 1'b0;
    det_w_d     = 1'b0;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    match_cnt_d = match_cnt_q;
    win         = (bus.req0 && bus.req1) ? ~last_gnt_q : bus.req1;

    acc_inc = acc_q;
    if (bus.det_z && (acc_q != '1)) acc_inc = acc_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          owner_d    = win;
          last_gnt_d = win;
          shreg_d    = win ? bus.data1 : bus.data0;
          acc_d      = '0;
          ack0_d     = ~win;
          ack1_d     = win;
          det_clr_d  = 1'b1;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        idx_d   = '0;
        det_w_d = shreg_q[WIDTH-1];
        shreg_d = shreg_q << 1;
        state_d = SHIFT;
      end
      SHIFT: begin
        // z lags det_w by one edge, so the first SHIFT cycle has nothing to sample yet.
        if (idx_q != '0) acc_d = acc_inc;
        if (idx_q == IDX_W'(WIDTH - 1)) begin
          state_d = TAIL;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          det_w_d = shreg_q[WIDTH-1];
          shreg_d = shreg_q << 1;
        end
      end
      TAIL: begin
        acc_d       = acc_inc;
        done_d      = 1'b1;
        done_id_d   = owner_q;
        match_cnt_d = acc_inc;
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.det_clr   = det_clr_q;
  assign bus.det_w     = det_w_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;
  assign bus.match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Bench for seq_det_arbiter: behavioural 1001 detector plus a word-level reference model
// for arbitration order, serial bit order, timing and per-word match counts.
module tb_seq_det_arbiter;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_ack_cyc = 0;
  bit   m_last;

  seq_det_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  seq_det_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Detector: Moore 1001 over the last four bits clocked in, synchronously cleared.
  logic [2:0] hist;
  logic       z_m;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      z_m  <= 1'b0;
    end else if (bus.det_clr) begin
      hist <= '0;
      z_m  <= 1'b0;
    end else begin
      z_m  <= ({hist, bus.det_w} == 4'b1001);
      hist <= {hist[1:0], bus.det_w};
    end
  end
  assign bus.det_z = z_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_matches(input logic [WIDTH-1:0] w);
    int n = 0;
    for (int i = 0; i <= WIDTH - 4; i++)
      if (((w >> i) & 4'hF) == 4'b1001) n++;
    if (n > (1 << CNT_W) - 1) n = (1 << CNT_W) - 1;
    return n;
  endfunction

  task automatic run_word(input bit r0, input bit r1,
                          input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                          input bit keep);
    bit               win;
    bit               seen;
    logic [WIDTH-1:0] w;
    int               n;
    bus.req0  = r0;
    bus.req1  = r1;
    bus.data0 = d0;
    bus.data1 = d1;
    win    = (r0 && r1) ? ~m_last : r1;
    m_last = win;
    w      = win ? d1 : d0;
    n      = exp_matches(w);
    seen   = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.ack0 | bus.ack1;
    end
    chk("ack_timeout", 32'(seen), 32'd1);
    if (!seen) return;
    last_ack_cyc = cyc;
    chk("ack0", 32'(bus.ack0), 32'(!win));
    chk("ack1", 32'(bus.ack1), 32'(win));
    chk("det_clr_on", 32'(bus.det_clr), 32'd1);
    chk("busy_on", 32'(bus.busy), 32'd1);
    if (!keep) begin
      if (win) bus.req1 = 1'b0;
      else     bus.req0 = 1'b0;
    end
    for (int k = 0; k < WIDTH; k++) begin
      @(negedge clk);
      chk("det_w", 32'(bus.det_w), 32'(w[WIDTH-1-k]));
      if (k == 0) begin
        chk("det_clr_off", 32'(bus.det_clr), 32'd0);
        chk("ack_off", 32'(bus.ack0 | bus.ack1), 32'd0);
      end
    end
    @(negedge clk);
    chk("tail_w", 32'(bus.det_w), 32'd0);
    chk("tail_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("done", 32'(bus.done), 32'd1);
    chk("done_id", 32'(bus.done_id), 32'(win));
    chk("match_cnt", 32'(bus.match_cnt), 32'(n));
    @(negedge clk);
    chk("done_drop", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("cnt_hold", 32'(bus.match_cnt), 32'(n));
  endtask

  initial begin
    int prev;
    bit seen;
    rst       = 1'b1;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.data0 = '0;
    bus.data1 = '0;
    m_last    = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ack", 32'({bus.ack0, bus.ack1}), 32'd0);
    chk("rst_det", 32'({bus.det_clr, bus.det_w}), 32'd0);
    chk("rst_id", 32'(bus.done_id), 32'd0);
    chk("rst_cnt", 32'(bus.match_cnt), 32'd0);
    rst = 1'b0;

    run_word(1, 0, 8'b10011001, 8'h00, 0);
    run_word(0, 1, 8'h00, 8'b10010010, 0);
    run_word(1, 0, 8'b11110000, 8'h00, 0);
    run_word(1, 0, 8'b00000100, 8'h00, 0);
    run_word(1, 0, 8'b10000000, 8'h00, 0);

    // Both requests held continuously: grants alternate back to back.
    for (int i = 0; i < 4; i++) begin
      prev = last_ack_cyc;
      run_word(1, 1, 8'(8'h99 + i), 8'(8'h92 + i), 1);
      if (i > 0) chk("ack_spacing", 32'(last_ack_cyc - prev), 32'd12);
    end
    run_word(1, 0, 8'b10010011, 8'h00, 0);
    run_word(1, 0, 8'b00110010, 8'h00, 0);

    for (int i = 0; i < 24; i++) begin
      int r;
      r = $urandom_range(1, 3);
      run_word(r[0], r[1], 8'($urandom), 8'($urandom), 0);
    end

    // Asynchronous reset in the middle of a word.
    bus.req0  = 1'b1;
    bus.req1  = 1'b0;
    bus.data0 = 8'b10011001;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.ack0;
    end
    chk("mid_ack_timeout", 32'(seen), 32'd1);
    bus.req0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_w_before", 32'(bus.det_w), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_w", 32'(bus.det_w), 32'd0);
    chk("mid_rst_ack", 32'({bus.ack0, bus.ack1}), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("mid_rst_hold_done", 32'(bus.done), 32'd0);
    rst    = 1'b0;
    m_last = 1'b1;
    run_word(1, 1, 8'b10011001, 8'hFF, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=finish", cyc);
    $fatal(1, "bench timeout");
  end

endmodule
